// File: rtl/i2c_arb_pkg.sv
// Shared types and widths for the I2C response-load arbiter.
package i2c_arb_pkg;

  localparam int unsigned SEND_W = 17;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned IDX_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ARMED = 2'd2,
    ST_XFER  = 2'd3
  } i2c_arb_st_t;

  // Payload presented to the i2c_sink send-data port.
  typedef struct packed {
    logic              en;
    logic [DATA_W-1:0] data;
  } send_t;

endpackage

// File: rtl/i2c_bus_mon.sv
// I2C bus observer: synchronizes SCL/SDA, detects START/STOP, tracks bus
// occupancy and counts idle cycles since the last bus event.
module i2c_bus_mon #(
  parameter int unsigned IDLE_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  input  logic force_idle_i,
  output logic start_c,
  output logic stop_c,
  output logic bus_active_o,
  output logic gap_full_c
);

  localparam int unsigned GAP_W = $clog2(IDLE_CYC + 1);

  // bit 1 = SCL, bit 0 = SDA
  logic [1:0]       s1_q, s1_d, s2_q, s2_d, e_q, e_d;
  logic             bus_active_q, bus_active_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

  // Two-flop synchronizer followed by a one-flop edge register.
  always_comb begin
    s1_d = {scl_i, sda_i};
    s2_d = s1_q;
    e_d  = s2_q;
  end

  assign start_c = s2_q[1] & e_q[1] &  e_q[0] & ~s2_q[0];
  assign stop_c  = s2_q[1] & e_q[1] & ~e_q[0] &  s2_q[0];

  // Bus occupancy and saturating idle-gap counter.
  always_comb begin
    bus_active_d = bus_active_q;
    gap_cnt_d    = gap_cnt_q;
    if (force_idle_i) begin
      bus_active_d = 1'b0;
      gap_cnt_d    = '0;
    end else if (start_c) begin
      bus_active_d = 1'b1;
      gap_cnt_d    = '0;
    end else if (stop_c) begin
      bus_active_d = 1'b0;
      gap_cnt_d    = '0;
    end else if (!bus_active_q && (gap_cnt_q != GAP_W'(IDLE_CYC))) begin
      gap_cnt_d = gap_cnt_q + GAP_W'(1);
    end
  end

  // Monitor registers; synchronizers reset to the idle bus level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q         <= 2'b11;
      s2_q         <= 2'b11;
      e_q          <= 2'b11;
      bus_active_q <= 1'b0;
      gap_cnt_q    <= '0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      e_q          <= e_d;
      bus_active_q <= bus_active_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  assign bus_active_o = bus_active_q;
  assign gap_full_c   = (gap_cnt_q == GAP_W'(IDLE_CYC));

endmodule

// File: rtl/i2c_resp_arbiter.sv
// Round-robin arbiter sharing the i2c_sink response-load port: loads at most
// one word per I2C transaction, only after the bus has been idle long enough.
// Optional transaction timeout enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_resp_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned IDLE_CYC    = 16,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  logic                    scl_i,
  input  logic                    sda_i,
  output logic [SEND_W-1:0]       send_o,
  output logic [IDX_W-1:0]        grant_idx_o,
  output logic                    busy_o,
  output logic                    timeout_o
);

  i2c_arb_st_t       state_q, state_d;
  send_t             send_q, send_d;
  logic [N_REQ-1:0]  ready_q, ready_d, win_oh_c;
  logic [IDX_W-1:0]  grant_q, grant_d, win_idx_c;
  logic [DATA_W-1:0] win_data_c;
  logic              busy_q, busy_d, timeout_q, timeout_d;
  logic              win_found_c, load_ok_c, to_hit_c;
  logic              start_c, stop_c, bus_active_c, gap_full_c;
  int unsigned       dist_c, best_c;

  i2c_bus_mon #(
    .IDLE_CYC(IDLE_CYC)
  ) u_bus_mon (
    .clk         (clk),
    .rst         (rst),
    .scl_i       (scl_i),
    .sda_i       (sda_i),
    .force_idle_i(to_hit_c),
    .start_c     (start_c),
    .stop_c      (stop_c),
    .bus_active_o(bus_active_c),
    .gap_full_c  (gap_full_c)
  );

  // Round-robin pick: smallest rotated distance from (last+1) among valid requesters.
  always_comb begin
    win_found_c = 1'b0;
    win_idx_c   = '0;
    win_oh_c    = '0;
    win_data_c  = '0;
    dist_c      = 0;
    best_c      = N_REQ;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      dist_c = (j + N_REQ - 1 - 32'(grant_q)) % N_REQ;
      if (req_valid_i[j] && (dist_c < best_c)) begin
        best_c      = dist_c;
        win_found_c = 1'b1;
        win_idx_c   = IDX_W'(j);
        win_oh_c    = '0;
        win_oh_c[j] = 1'b1;
        win_data_c  = req_data_i[j*DATA_W +: DATA_W];
      end
    end
  end

  // A START seen in the same cycle also blocks the load.
  assign load_ok_c = (state_q == ST_IDLE) && !bus_active_c && gap_full_c &&
                     !start_c && win_found_c;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Cycles spent in the current transfer.
  always_comb begin
    to_cnt_d = '0;
    if (state_q == ST_XFER) to_cnt_d = to_cnt_q + TO_W'(1);
  end

  assign to_hit_c = (state_q == ST_XFER) && !stop_c &&
                    (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

  // Transfer timeout counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`else
  assign to_hit_c = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (load_ok_c) state_d = ST_LOAD;
      ST_LOAD:  state_d = start_c ? ST_XFER : ST_ARMED;
      ST_ARMED: if (start_c) state_d = ST_XFER;
      ST_XFER:  if (stop_c || to_hit_c) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs, computed one cycle ahead so they register alongside the state.
  always_comb begin
    send_d    = '{en: 1'b0, data: send_q.data};
    ready_d   = '0;
    grant_d   = grant_q;
    busy_d    = (state_d != ST_IDLE);
    timeout_d = to_hit_c;
    if (load_ok_c) begin
      send_d  = '{en: 1'b1, data: win_data_c};
      ready_d = win_oh_c;
      grant_d = win_idx_c;
    end
  end

  // Output registers; grant_q doubles as the round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      send_q    <= '0;
      ready_q   <= '0;
      grant_q   <= IDX_W'(N_REQ - 1);
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      send_q    <= send_d;
      ready_q   <= ready_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign send_o      = send_q;
  assign req_ready_o = ready_q;
  assign grant_idx_o = grant_q;
  assign busy_o      = busy_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_i2c_resp_arbiter.sv
// Scoreboard bench for i2c_resp_arbiter: stimulus pushes expected loads,
// a forked monitor pops and compares whenever send_o[16] is asserted.
module tb_i2c_resp_arbiter;

  localparam int unsigned N_REQ       = 4;
  localparam int unsigned IDLE_CYC    = 16;
  localparam int unsigned TIMEOUT_CYC = 100;

  typedef struct packed {
    logic [16:0] send;
    logic [3:0]  ready;
    logic [2:0]  idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready_o;
  logic        scl, sda;
  logic [16:0] send_o;
  logic [2:0]  grant_idx_o;
  logic        busy_o, timeout_o;

  int   tests = 0;
  int   fails = 0;
  int   busy_falls = 0;
  exp_t exp_q[$];

  i2c_resp_arbiter #(
    .N_REQ      (N_REQ),
    .IDLE_CYC   (IDLE_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid_i(req_valid),
    .req_data_i (req_data),
    .req_ready_o(req_ready_o),
    .scl_i      (scl),
    .sda_i      (sda),
    .send_o     (send_o),
    .grant_idx_o(grant_idx_o),
    .busy_o     (busy_o),
    .timeout_o  (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_data(input int idx, input logic [15:0] d);
    req_data[idx*16 +: 16] = d;
  endtask

  task automatic expect_load(input int idx, input logic [15:0] d);
    exp_t e;
    e.send  = {1'b1, d};
    e.ready = 4'(1) << idx;
    e.idx   = 3'(idx);
    exp_q.push_back(e);
  endtask

  // Counts negedges until a load appears; an expired bound counts as a failure.
  task automatic wait_load(input int max, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!send_o[16] && cyc < max);
    if (!send_o[16]) check("load_wait_timeout", 32'(send_o[16]), 32'd1);
  endtask

  task automatic i2c_start();
    sda = 1'b0; cycles(4);
    scl = 1'b0; cycles(4);
  endtask

  task automatic i2c_rep_start();
    sda = 1'b1; cycles(4);
    scl = 1'b1; cycles(4);
    sda = 1'b0; cycles(4);
    scl = 1'b0; cycles(4);
  endtask

  // Returns on the negedge at which SDA rises (the STOP pin edge).
  task automatic i2c_stop();
    sda = 1'b0; cycles(2);
    scl = 1'b1; cycles(4);
    sda = 1'b1;
  endtask

  task automatic monitor();
    exp_t e;
    logic prev_busy;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_busy && !busy_o) busy_falls++;
      prev_busy = busy_o;
      if (send_o[16]) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_load: got send %0h ready %0h idx %0d expected no load",
                   send_o, req_ready_o, grant_idx_o);
        end else begin
          e = exp_q.pop_front();
          check("load_send", 32'(send_o), 32'(e.send));
          check("load_ready", 32'(req_ready_o), 32'(e.ready));
          check("load_idx", 32'(grant_idx_o), 32'(e.idx));
        end
      end else begin
        check("ready_without_load", 32'(req_ready_o), 32'd0);
      end
    end
  endtask

  initial begin
    int cyc;
    int falls0;
    fork
      monitor();
    join_none

    rst = 1'b1; scl = 1'b1; sda = 1'b1; req_valid = '0; req_data = '0;
    cycles(3);
    check("rst_send", 32'(send_o), 32'd0);
    check("rst_ready", 32'(req_ready_o), 32'd0);
    check("rst_grant", 32'(grant_idx_o), 32'd3);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_timeout", 32'(timeout_o), 32'd0);

    // Single requester after reset: load 17 cycles after reset release.
    set_data(0, 16'hA55A);
    req_valid = 4'b0001;
    expect_load(0, 16'hA55A);
    rst = 1'b0;
    wait_load(40, cyc);
    check("t1_latency", 32'(cyc), 32'd17);
    check("t1_send", 32'(send_o), 32'h1A55A);
    check("t1_grant", 32'(grant_idx_o), 32'd0);
    req_valid = 4'b0000;
    cycles(1);
    check("t1_pulse_width", 32'(send_o[16]), 32'd0);
    check("t1_armed_busy", 32'(busy_o), 32'd1);
    check("t1_held_data", 32'(send_o), 32'h0A55A);

    // All four requesting: one grant per transaction in order 0,1,2,3.
    rst = 1'b1; cycles(1); rst = 1'b0;
    set_data(0, 16'h1111); set_data(1, 16'h2222);
    set_data(2, 16'h3333); set_data(3, 16'h4444);
    req_valid = 4'b1111;
    expect_load(0, 16'h1111);
    wait_load(40, cyc);
    check("t2_first_latency", 32'(cyc), 32'd17);
    for (int k = 1; k < 4; k++) begin
      expect_load(k, 16'h1111 * 16'(k + 1));
      i2c_start();
      i2c_stop();
      wait_load(40, cyc);
      check("t2_gap_latency", 32'(cyc), 32'd20);
    end
    req_valid = 4'b0000;

    // START inside the idle gap blocks loading until STOP plus the full gap.
    i2c_start();
    i2c_stop();
    cycles(8);
    req_valid = 4'b0001;
    i2c_start();
    cycles(40);
    check("t3_blocked_busy", 32'(busy_o), 32'd0);
    expect_load(0, 16'h1111);
    i2c_stop();
    wait_load(40, cyc);
    check("t3_gap_latency", 32'(cyc), 32'd20);
    req_valid = 4'b0000;

    // START, repeated START, STOP with a word armed.
    falls0 = busy_falls;
    i2c_start();
    check("t4_xfer_busy", 32'(busy_o), 32'd1);
    i2c_rep_start();
    check("t4_rep_busy", 32'(busy_o), 32'd1);
    i2c_stop();
    cycles(2);
    check("t4_busy_hold", 32'(busy_o), 32'd1);
    cycles(1);
    check("t4_busy_fall", 32'(busy_o), 32'd0);
    cycles(10);
    check("t4_one_fall", 32'(busy_falls - falls0), 32'd1);

    // Reset while armed drops the word; a new request follows the normal gap.
    req_valid = 4'b0010;
    expect_load(1, 16'h2222);
    wait_load(40, cyc);
    req_valid = 4'b0000;
    cycles(3);
    check("t5_armed_busy", 32'(busy_o), 32'd1);
    rst = 1'b1;
    #1;
    check("t5_rst_send", 32'(send_o), 32'd0);
    check("t5_rst_ready", 32'(req_ready_o), 32'd0);
    check("t5_rst_grant", 32'(grant_idx_o), 32'd3);
    check("t5_rst_busy", 32'(busy_o), 32'd0);
    check("t5_rst_timeout", 32'(timeout_o), 32'd0);
    cycles(2);
    req_valid = 4'b0100;
    expect_load(2, 16'h3333);
    rst = 1'b0;
    wait_load(40, cyc);
    check("t5_regrant_latency", 32'(cyc), 32'd17);
    req_valid = 4'b0000;
    cycles(2);

`ifdef I2C_ARB_TIMEOUT_EN
    // START with no STOP: timeout 100 cycles after entering the transfer.
    sda = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!timeout_o && cyc < 200);
    check("t6_timeout_latency", 32'(cyc), 32'd103);
    check("t6_timeout_idle", 32'(busy_o), 32'd0);
    cycles(1);
    check("t6_timeout_pulse", 32'(timeout_o), 32'd0);
    i2c_stop();
    cycles(4);
    check("t6_after_stop_busy", 32'(busy_o), 32'd0);
`endif

    cycles(5);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
